// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   - state_t : controller state encodings
//   - ctrl_t  : bundle of the five pipeline control outputs
//   - load_use_hit() : load-use detection between the EX load and the ID operands
package pipe_hazard_ctrl_pkg;

  localparam int unsigned REG_W             = 5;
  localparam int unsigned MD_CYCLES_DEFAULT = 32;

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_MD_BUSY  = 2'd2
  } state_t;

  typedef struct packed {
    logic pc_wen;
    logic if_id_wen;
    logic if_id_flush;
    logic id_ex_flush;
    logic mem_stall;
  } ctrl_t;

  // Register 0 is hard-wired zero, so a load targeting it never creates a hazard.
  function automatic logic load_use_hit(
    input logic [REG_W-1:0] id_rs,
    input logic [REG_W-1:0] id_rt,
    input logic             id_use_rs,
    input logic             id_use_rt,
    input logic             ex_mem_read,
    input logic [REG_W-1:0] ex_rt
  );
    return ex_mem_read && (ex_rt != '0) &&
           ((id_use_rs && (id_rs == ex_rt)) || (id_use_rt && (id_rt == ex_rt)));
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side signal bundle of the hazard controller.
//   master : pipeline (decode, EX resolver, dmem handshake, mult/div) drives
//            the hazard inputs and receives the stall/flush controls
//   slave  : the hazard controller itself
interface pipe_hazard_ctrl_if;
  import pipe_hazard_ctrl_pkg::*;

  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic             ex_mem_read;
  logic [REG_W-1:0] ex_rt;
  logic             branch_taken;
  logic             dmem_req;
  logic             dmem_ready;
  logic             md_start;
  logic             id_use_hilo;

  logic             pc_wen;
  logic             if_id_wen;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             mem_stall;

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, ex_mem_read, ex_rt,
           branch_taken, dmem_req, dmem_ready, md_start, id_use_hilo,
    input  pc_wen, if_id_wen, if_id_flush, id_ex_flush, mem_stall
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, ex_mem_read, ex_rt,
           branch_taken, dmem_req, dmem_ready, md_start, id_use_hilo,
    output pc_wen, if_id_wen, if_id_flush, id_ex_flush, mem_stall
  );
endinterface

// File: rtl/pipe_hazard_ctrl_md_busy_counter.sv
// Mult/div busy down-counter.
//   clk, rst  : clock, synchronous active-high reset (clears the count)
//   load      : load load_val (takes priority over dec)
//   load_val  : value to load
//   dec       : decrement; ignored once the count reaches zero
//   zero      : count is zero
module md_busy_counter #(
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] md_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      md_cnt <= '0;
    end else if (load) begin
      md_cnt <= load_val;
    end else if (dec && (md_cnt != '0)) begin
      md_cnt <= md_cnt - 1'b1;
    end
  end

  assign zero = (md_cnt == '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage MIPS-lite pipeline.
// Resolves load-use hazards, taken branches/jumps, multi-cycle data-memory
// accesses and the iterative mult/div unit. Outputs are combinational from
// the current state and inputs so a stall acts in the same cycle.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   hz (slave)    : hazard inputs and pc_wen / if_id_wen / if_id_flush /
//                   id_ex_flush / mem_stall controls
//   stall_cycles  : saturating count of cycles with pc_wen=0 outside reset,
//                   present only when PIPE_STALL_CNT_EN is defined
// Parameters:
//   MD_CYCLES : busy cycles of the mult/div unit after md_start (>= 2)
//   CNT_W     : width of the mult/div down-counter (must hold MD_CYCLES)
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned MD_CYCLES = MD_CYCLES_DEFAULT,
  parameter int unsigned CNT_W     = 6
) (
  input  logic              clk,
  input  logic              rst,
  pipe_hazard_ctrl_if.slave hz
`ifdef PIPE_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cycles
`endif
);

  state_t state;
  state_t next_state;
  ctrl_t  ctrl;

  logic md_load;
  logic md_dec;
  logic md_zero;
  logic mem_pend;
  logic mem_hold;
  logic load_use;
  logic hilo_block;

  assign mem_pend = hz.dmem_req & ~hz.dmem_ready;
  assign load_use = load_use_hit(hz.id_rs, hz.id_rt, hz.id_use_rs, hz.id_use_rt,
                                 hz.ex_mem_read, hz.ex_rt);

  always_comb begin
    next_state = state;
    md_load    = 1'b0;
    md_dec     = 1'b0;
    mem_hold   = 1'b0;
    hilo_block = 1'b0;

    case (state)
      S_RUN: begin
        mem_hold = mem_pend;
        if (mem_hold) begin
          next_state = S_MEM_WAIT;
        end else if (hz.md_start) begin
          md_load    = 1'b1;
          next_state = S_MD_BUSY;
        end
      end
      S_MEM_WAIT: begin
        // Once waiting, only dmem_ready matters; dmem_req is not re-sampled.
        mem_hold = ~hz.dmem_ready;
        if (!mem_hold) next_state = S_RUN;
      end
      S_MD_BUSY: begin
        mem_hold = mem_pend;
        // HI/LO consumers are released in the same cycle the count reaches zero.
        hilo_block = hz.id_use_hilo & ~md_zero;
        if (!mem_hold) begin
          if (md_zero) next_state = S_RUN;
          else         md_dec     = 1'b1;
        end
      end
      default: next_state = S_RUN;
    endcase

    if (rst) begin
      ctrl = '{pc_wen: 1'b0, if_id_wen: 1'b0, if_id_flush: 1'b1,
               id_ex_flush: 1'b1, mem_stall: 1'b0};
    end else if (mem_hold) begin
      // A taken branch is held in EX while memory is outstanding.
      ctrl = '{pc_wen: 1'b0, if_id_wen: 1'b0, if_id_flush: 1'b0,
               id_ex_flush: 1'b0, mem_stall: 1'b1};
    end else if (hz.branch_taken) begin
      // Branch beats load-use: the stalled instruction is on the wrong path.
      ctrl = '{pc_wen: 1'b1, if_id_wen: 1'b1, if_id_flush: 1'b1,
               id_ex_flush: 1'b1, mem_stall: 1'b0};
    end else if (load_use || hilo_block) begin
      ctrl = '{pc_wen: 1'b0, if_id_wen: 1'b0, if_id_flush: 1'b0,
               id_ex_flush: 1'b1, mem_stall: 1'b0};
    end else begin
      ctrl = '{pc_wen: 1'b1, if_id_wen: 1'b1, if_id_flush: 1'b0,
               id_ex_flush: 1'b0, mem_stall: 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_RUN;
    else     state <= next_state;
  end

  md_busy_counter #(
    .CNT_W (CNT_W)
  ) u_md_busy_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (md_load),
    .load_val (CNT_W'(MD_CYCLES - 1)),
    .dec      (md_dec),
    .zero     (md_zero)
  );

  assign hz.pc_wen      = ctrl.pc_wen;
  assign hz.if_id_wen   = ctrl.if_id_wen;
  assign hz.if_id_flush = ctrl.if_id_flush;
  assign hz.id_ex_flush = ctrl.id_ex_flush;
  assign hz.mem_stall   = ctrl.mem_stall;

`ifdef PIPE_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (!ctrl.pc_wen && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage MIPS-lite pipeline.
- Drives PC write enable and the wen/flush pins of the IF/ID and ID/EX pipeline registers.
- Resolves four conditions: load-use hazards, taken branches/jumps, multi-cycle data-memory accesses, and the iterative multiply/divide unit.
- Sits between the decode stage, the EX-stage branch resolver, the data-memory handshake and the mult/div unit.

Parameters:
- MD_CYCLES, 32, cycles the mult/div unit stays busy after md_start (must be >= 2).
- CNT_W, 6, width of the internal mult/div down-counter (must hold MD_CYCLES).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- id_rs  in  5  rs field of the instruction in ID
- id_rt  in  5  rt field of the instruction in ID
- id_use_rs  in  1  ID instruction reads rs
- id_use_rt  in  1  ID instruction reads rt
- ex_mem_read  in  1  instruction in EX is a load
- ex_rt  in  5  load destination register in EX
- branch_taken  in  1  EX resolved a taken branch/jump this cycle
- dmem_req  in  1  MEM stage issues a data-memory access this cycle
- dmem_ready  in  1  data memory completes the access this cycle
- md_start  in  1  EX launches a mult/div this cycle
- id_use_hilo  in  1  ID instruction is mfhi/mflo/mult/div
- pc_wen  out  1  PC write enable
- if_id_wen  out  1  IF/ID register write enable
- if_id_flush  out  1  IF/ID register flush
- id_ex_flush  out  1  ID/EX register flush (bubble insert)
- mem_stall  out  1  freeze EX/MEM and MEM/WB (held while waiting on memory)

Behaviour:
- State register, encodings in head.v: S_RUN, S_MEM_WAIT, S_MD_BUSY. Down-counter md_cnt (CNT_W bits).
- Reset: state <= S_RUN, md_cnt <= 0. While rst is high, outputs are: pc_wen=0, if_id_wen=0, if_id_flush=1, id_ex_flush=1, mem_stall=0.
- Outputs are combinational from the current state and current inputs, so a stall takes effect in the same cycle. Only state and md_cnt are registered.
- load_use = ex_mem_read & (ex_rt != 0) & ((id_use_rs & id_rs == ex_rt) | (id_use_rt & id_rt == ex_rt)).
- S_RUN priority, highest first:
  1. dmem_req & !dmem_ready: pc_wen=0, if_id_wen=0, id_ex_flush=0, mem_stall=1. Next state S_MEM_WAIT. Any branch_taken is held, not acted on.
  2. branch_taken: pc_wen=1, if_id_flush=1, id_ex_flush=1. Overrides load_use, because the load-use victim is on the wrong path.
  3. load_use: pc_wen=0, if_id_wen=0, id_ex_flush=1. This is a one-cycle bubble; stay in S_RUN.
  4. Otherwise: pc_wen=1, if_id_wen=1, all flushes 0.
- md_start is sampled in S_RUN whenever no memory stall is active. It sets md_cnt <= MD_CYCLES-1 and next state S_MD_BUSY. It may coincide with branch_taken, and both take effect.
- S_MEM_WAIT: pc_wen=0, if_id_wen=0, mem_stall=1, flushes 0. Leave on dmem_ready=1: that cycle outputs mem_stall=0, and the S_RUN rules 2–4 apply combinationally. Next state S_RUN.
- S_MD_BUSY:
  - md_cnt decrements every cycle except when a memory stall is active.
  - If id_use_hilo: treat as load_use (stall PC and IF/ID, bubble ID/EX).
  - Otherwise: normal flow, with branch_taken and load_use handled as in S_RUN.
  - A dmem_req & !dmem_ready here behaves as rule 1 but stays in S_MD_BUSY. The counter pauses while mem_stall=1.
  - At md_cnt==0 with no memory stall, next state S_RUN. id_use_hilo is released that same cycle.
  - A md_start while busy is ignored (decode must not issue it).
- Register index 0 never causes a hazard.
- A reset in any state aborts the operation immediately. The counter clears and no pending memory wait is retained.
- Flush has priority over wen in the pipeline registers, so outputs may assert both.

Optional Feature:
- Macro: PIPE_STALL_CNT_EN.
- With the macro defined, add output stall_cycles (32 bits). It is a saturating count of cycles with pc_wen=0 while rst=0. Reset clears it to 0. It holds at 32'hFFFF_FFFF.
- Without the macro, the port and its logic are absent.

Decomposition:
- head.v holds: state encodings S_RUN/S_MEM_WAIT/S_MD_BUSY, the 5-bit register-index width macro, and the MD_CYCLES default.
- One sub-module, md_busy_counter: load/decrement/pause counter with a zero flag, instantiated once.

Test Plan:
- Load-use: ex_mem_read=1, ex_rt=8, id_rs=8, id_use_rs=1 for one cycle -> pc_wen=0, if_id_wen=0, id_ex_flush=1 that cycle only. Same with ex_rt=0 -> no stall.
- Branch plus load-use in the same cycle -> if_id_flush=1, id_ex_flush=1, pc_wen=1. No stall.
- dmem_req=1 with dmem_ready low for 3 cycles -> mem_stall=1 and pc_wen=0 for 3 cycles. On the ready cycle mem_stall=0 and state returns to S_RUN.
- MD_CYCLES=4: md_start, then mfhi in ID on the next cycle -> stall for exactly 3 cycles, then pc_wen=1.
- Memory stall during S_MD_BUSY -> md_cnt holds its value. Total busy time extends by the stall length.
- rst asserted mid S_MEM_WAIT -> next cycle state is S_RUN and all outputs match the reset values. With PIPE_STALL_CNT_EN, stall_cycles==0.
